// File: rtl/dtc_pkg.sv
// Shared word constants, FSM encoding and CRC helper for the DTC gen2 transmitter.
// crc16_ccitt_word is only referenced by builds that define DTC_CRC16_EN.
package dtc_pkg;

    localparam logic [15:0] SYNC    = 16'hBC50;
    localparam logic [15:0] EVT_HDR = 16'h5C5C;
    localparam logic [15:0] RPL_HDR = 16'hF7F7;
    localparam logic [15:0] ST_HDR  = 16'hDCDC;
    localparam logic [15:0] EVT_END = 16'hC5D5;
    localparam logic [15:0] RD_TMO  = 16'hDEAD;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_EVT_HDR  = 4'd1,
        S_EVT_INFO = 4'd2,
        S_ADC      = 4'd3,
        S_TRL_CNT  = 4'd4,
        S_TRL_CHK  = 4'd5,
        S_TRL_END  = 4'd6,
        S_RD_WAIT  = 4'd7,
        S_RPL_HDR  = 4'd8,
        S_ADDR_H   = 4'd9,
        S_ADDR_L   = 4'd10,
        S_DATA_H   = 4'd11,
        S_DATA_L   = 4'd12,
        S_ST_HDR   = 4'd13,
        S_ST       = 4'd14
    } dtc_state_e;

    // CRC-16-CCITT (poly 0x1021) advanced over one 16-bit word, MSB first
    function automatic logic [15:0] crc16_ccitt_word(input logic [15:0] crc_in,
                                                     input logic [15:0] din);
        logic [15:0] crc;
        logic        fb;
        crc = crc_in;
        for (int i = 15; i >= 0; i--) begin
            fb  = crc[15] ^ din[i];
            crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return crc;
    endfunction

endpackage

// File: rtl/dtc_serializer.sv
// Word serializer: free-running slot counter, 16-bit shift register emitting
// 2*LANES bits per clock LSB-first, and the per-word strobe.
module dtc_serializer #(
    parameter int LANES = 2
) (
    input  logic                 dtc_clk,
    input  logic                 rst_n,
    input  logic [15:0]          word,
    output logic [2*LANES-1:0]   dtc_out,
    output logic                 word_strobe,
    output logic                 boundary
);
    localparam int WCYC   = 8 / LANES;
    localparam int SLOT_W = $clog2(WCYC);

    logic [SLOT_W-1:0] slot_r;
    logic [15:0]       shreg_r;
    logic              strobe_r;

    assign boundary    = (slot_r == {SLOT_W{1'b0}});
    assign dtc_out     = shreg_r[2*LANES-1:0];
    assign word_strobe = strobe_r;

    // Slot counter, word load on slot 0, shift on all other slots
    always_ff @(posedge dtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r   <= {SLOT_W{1'b0}};
            shreg_r  <= 16'h0000;
            strobe_r <= 1'b0;
        end else begin
            strobe_r <= boundary;
            shreg_r  <= boundary ? word : (shreg_r >> (2 * LANES));
            slot_r   <= (slot_r == SLOT_W'(WCYC - 1)) ? {SLOT_W{1'b0}} : slot_r + SLOT_W'(1);
        end
    end

endmodule

// File: rtl/dtc_tx_gen2.sv
// DTC gen2 link transmitter: event readouts, register read replies, status replies, SYNC filler.
// Define DTC_CRC16_EN to replace the XOR event checksum with CRC-16-CCITT.
module dtc_tx_gen2
    import dtc_pkg::*;
#(
    parameter int N_CH       = 64,
    parameter int ADC_W      = 12,
    parameter int MAX_WIN    = 64,
    parameter int LANES      = 2,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                          dtc_clk,
    input  logic                          rst_n,
    output logic [2*LANES-1:0]            dtc_out,
    output logic                          word_strobe,
    output logic                          busy,
    input  logic                          rdocmd,
    input  logic [$clog2(MAX_WIN):0]      event_window,
    input  logic [N_CH-1:0]               ch_mask,
    output logic [$clog2(N_CH)-1:0]       adc_rd_ch,
    output logic [$clog2(MAX_WIN)-1:0]    adc_rd_addr,
    input  logic [ADC_W-1:0]              adc_data,
    input  logic                          streq,
    input  logic [15:0]                   status,
    input  logic                          read,
    input  logic [31:0]                   address,
    input  logic [31:0]                   data,
    input  logic                          data_vld
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int LO_W  = CH_W + 1;
    localparam int AW    = $clog2(MAX_WIN);
    localparam int WIN_W = AW + 1;
    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

    dtc_state_e        state_r, state_nxt_s;
    logic              busy_r;
    logic              boundary_s;
    logic [15:0]       word_s;
    logic              pend_evt_r, pend_rd_r, pend_st_r;
    logic              take_evt_s, take_rd_s, take_st_s;
    logic [N_CH-1:0]   mask_r;
    logic [WIN_W-1:0]  win_r, win_clamp_s;
    logic [CH_W-1:0]   ch_r, nxt_ch_s;
    logic [AW-1:0]     addr_r;
    logic [LO_W-1:0]   lo_s;
    logic              nxt_found_s, first_ok_s, last_sample_s;
    logic [15:0]       cnt_r, chk_r, chk_upd_s, adc_word_s;
    logic [TMO_W-1:0]  wait_r;
    logic              seen_r, tmo_s;
    logic [31:0]       rd_addr_r, rd_data_r;

    dtc_serializer #(.LANES(LANES)) u_ser (
        .dtc_clk     (dtc_clk),
        .rst_n       (rst_n),
        .word        (word_s),
        .dtc_out     (dtc_out),
        .word_strobe (word_strobe),
        .boundary    (boundary_s)
    );

    assign busy        = busy_r;
    assign adc_rd_ch   = ch_r;
    assign adc_rd_addr = addr_r;
    assign adc_word_s  = 16'(adc_data);
    assign win_clamp_s = (event_window > WIN_W'(MAX_WIN)) ? WIN_W'(MAX_WIN) : event_window;

`ifdef DTC_CRC16_EN
    localparam logic [15:0] CHK_INIT = 16'hFFFF;
    assign chk_upd_s = crc16_ccitt_word(chk_r, adc_word_s);
`else
    localparam logic [15:0] CHK_INIT = 16'h0000;
    assign chk_upd_s = chk_r ^ adc_word_s;
`endif

    // Requests are only taken in IDLE on a word boundary, event > read > status
    assign take_evt_s = boundary_s && (state_r == S_IDLE) && pend_evt_r;
    assign take_rd_s  = boundary_s && (state_r == S_IDLE) && !pend_evt_r && pend_rd_r;
    assign take_st_s  = boundary_s && (state_r == S_IDLE) && !pend_evt_r && !pend_rd_r && pend_st_r;

    assign lo_s = (state_r == S_EVT_INFO) ? {LO_W{1'b0}} : ({1'b0, ch_r} + {{CH_W{1'b0}}, 1'b1});
    assign first_ok_s    = (win_r != {WIN_W{1'b0}}) && nxt_found_s;
    assign last_sample_s = (addr_r == {AW{1'b0}}) && !nxt_found_s;
    assign tmo_s         = (wait_r == TMO_W'(RD_TIMEOUT - 1));

    // Lowest enabled channel at or above lo_s
    always_comb begin
        logic hit;
        nxt_found_s = 1'b0;
        nxt_ch_s    = {CH_W{1'b0}};
        for (int i = N_CH - 1; i >= 0; i--) begin
            hit         = mask_r[i] & (LO_W'(i) >= lo_s);
            nxt_found_s = nxt_found_s | hit;
            nxt_ch_s    = hit ? CH_W'(i) : nxt_ch_s;
        end
    end

    // State register and busy flag, advanced once per word
    always_ff @(posedge dtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
        end else if (boundary_s) begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != S_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (pend_evt_r)     state_nxt_s = S_EVT_HDR;
                else if (pend_rd_r) state_nxt_s = S_RD_WAIT;
                else if (pend_st_r) state_nxt_s = S_ST_HDR;
                else                state_nxt_s = S_IDLE;
            end
            S_EVT_HDR:  state_nxt_s = S_EVT_INFO;
            S_EVT_INFO: begin
                if (first_ok_s) state_nxt_s = S_ADC;
                else            state_nxt_s = S_TRL_CNT;
            end
            S_ADC: begin
                if (last_sample_s) state_nxt_s = S_TRL_CNT;
                else               state_nxt_s = S_ADC;
            end
            S_TRL_CNT:  state_nxt_s = S_TRL_CHK;
            S_TRL_CHK:  state_nxt_s = S_TRL_END;
            S_TRL_END:  state_nxt_s = S_IDLE;
            S_RD_WAIT: begin
                if (seen_r || data_vld || tmo_s) state_nxt_s = S_RPL_HDR;
                else                             state_nxt_s = S_RD_WAIT;
            end
            S_RPL_HDR:  state_nxt_s = S_ADDR_H;
            S_ADDR_H:   state_nxt_s = S_ADDR_L;
            S_ADDR_L:   state_nxt_s = S_DATA_H;
            S_DATA_H:   state_nxt_s = S_DATA_L;
            S_DATA_L:   state_nxt_s = S_IDLE;
            S_ST_HDR:   state_nxt_s = S_ST;
            S_ST:       state_nxt_s = S_IDLE;
            default:    state_nxt_s = S_IDLE;
        endcase
    end

    // Word to load at the next boundary for the current state
    always_comb begin
        word_s = SYNC;
        case (state_r)
            S_IDLE:     word_s = SYNC;
            S_EVT_HDR:  word_s = EVT_HDR;
            S_EVT_INFO: word_s = 16'(win_r);
            S_ADC:      word_s = adc_word_s;
            S_TRL_CNT:  word_s = cnt_r;
            S_TRL_CHK:  word_s = chk_r;
            S_TRL_END:  word_s = EVT_END;
            S_RD_WAIT:  word_s = SYNC;
            S_RPL_HDR:  word_s = RPL_HDR;
            S_ADDR_H:   word_s = rd_addr_r[31:16];
            S_ADDR_L:   word_s = rd_addr_r[15:0];
            S_DATA_H:   word_s = rd_data_r[31:16];
            S_DATA_L:   word_s = rd_data_r[15:0];
            S_ST_HDR:   word_s = ST_HDR;
            S_ST:       word_s = status;
            default:    word_s = SYNC;
        endcase
    end

    // Sticky request flags; taking a request wins over a coincident pulse
    always_ff @(posedge dtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_evt_r <= 1'b0;
            pend_rd_r  <= 1'b0;
            pend_st_r  <= 1'b0;
        end else begin
            pend_evt_r <= take_evt_s ? 1'b0 : (pend_evt_r | rdocmd);
            pend_rd_r  <= take_rd_s  ? 1'b0 : (pend_rd_r  | read);
            pend_st_r  <= take_st_s  ? 1'b0 : (pend_st_r  | streq);
        end
    end

    // Event capture, sample cursor (address for word n+1 set at word n's load) and trailer
    always_ff @(posedge dtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r <= {N_CH{1'b0}};
            win_r  <= {WIN_W{1'b0}};
            ch_r   <= {CH_W{1'b0}};
            addr_r <= {AW{1'b0}};
            cnt_r  <= 16'h0000;
            chk_r  <= 16'h0000;
        end else if (boundary_s) begin
            case (state_r)
                S_IDLE: begin
                    if (pend_evt_r) begin
                        mask_r <= ch_mask;
                        win_r  <= win_clamp_s;
                        cnt_r  <= 16'h0000;
                        chk_r  <= CHK_INIT;
                    end
                end
                S_EVT_INFO: begin
                    if (first_ok_s) begin
                        ch_r   <= nxt_ch_s;
                        addr_r <= AW'(win_r - WIN_W'(1));
                    end
                end
                S_ADC: begin
                    cnt_r <= cnt_r + 16'd1;
                    chk_r <= chk_upd_s;
                    if (addr_r != {AW{1'b0}}) begin
                        addr_r <= addr_r - AW'(1);
                    end else if (nxt_found_s) begin
                        ch_r   <= nxt_ch_s;
                        addr_r <= AW'(win_r - WIN_W'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    // Read reply capture: first data_vld in RD_WAIT, or the timeout filler
    always_ff @(posedge dtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_r    <= 1'b0;
            wait_r    <= {TMO_W{1'b0}};
            rd_addr_r <= 32'h0000_0000;
            rd_data_r <= 32'h0000_0000;
        end else if (state_r == S_RD_WAIT) begin
            if (data_vld && !seen_r) begin
                seen_r    <= 1'b1;
                rd_addr_r <= address;
                rd_data_r <= data;
            end else if (boundary_s && !seen_r && tmo_s) begin
                rd_addr_r <= address;
                rd_data_r <= {RD_TMO, RD_TMO};
            end
            if (boundary_s) begin
                wait_r <= wait_r + TMO_W'(1);
            end
        end else begin
            seen_r <= 1'b0;
            wait_r <= {TMO_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_dtc_tx_gen2.sv
// Self-checking bench for dtc_tx_gen2 (LANES=2, RD_TIMEOUT=3): words are rebuilt from
// dtc_out and compared against directed expectations and a small ADC/checksum model.
module tb_dtc_tx_gen2;
    localparam int LANES = 2;
    localparam int WCYC  = 8 / LANES;
    localparam logic [15:0] SYNC_W = 16'hBC50;

    typedef struct {
        logic [6:0]  win;
        logic [63:0] mask;
        logic [15:0] exp_info;
        logic [15:0] exp_cnt;
    } evt_vec_t;

    logic              dtc_clk = 1'b0;
    logic              rst_n;
    logic [3:0]        dtc_out;
    logic              word_strobe, busy;
    logic              rdocmd, streq, read, data_vld;
    logic [6:0]        event_window;
    logic [63:0]       ch_mask;
    logic [5:0]        adc_rd_ch, adc_rd_addr;
    logic [11:0]       adc_data = 12'h000;
    logic [15:0]       status;
    logic [31:0]       address, data;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] wq[$];
    int          idx = 0;
    logic [15:0] acc = 16'h0000;
    evt_vec_t    vecs[7];

    always #5 dtc_clk = ~dtc_clk;

    dtc_tx_gen2 #(.N_CH(64), .ADC_W(12), .MAX_WIN(64), .LANES(LANES), .RD_TIMEOUT(3)) dut (
        .dtc_clk(dtc_clk), .rst_n(rst_n), .dtc_out(dtc_out), .word_strobe(word_strobe),
        .busy(busy), .rdocmd(rdocmd), .event_window(event_window), .ch_mask(ch_mask),
        .adc_rd_ch(adc_rd_ch), .adc_rd_addr(adc_rd_addr), .adc_data(adc_data),
        .streq(streq), .status(status), .read(read), .address(address), .data(data),
        .data_vld(data_vld)
    );

    function automatic logic [11:0] adc_f(input logic [5:0] ch, input logic [5:0] a);
        return {ch, a} ^ 12'h5A3;
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c ^ d;
        for (int k = 0; k < 16; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // Sample memory with one clock read latency
    always @(posedge dtc_clk) adc_data <= adc_f(adc_rd_ch, adc_rd_addr);

    // Rebuild words from the serial slices
    always @(negedge dtc_clk) begin
        if (!rst_n) begin
            idx = 0;
        end else begin
            if (word_strobe) begin
                acc = 16'(dtc_out);
                idx = 1;
            end else if (idx != 0) begin
                acc = acc | (16'(dtc_out) << (2 * LANES * idx));
                idx++;
            end
            if (idx == WCYC) begin
                wq.push_back(acc);
                idx = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic get_word(output logic [15:0] w);
        int n = 0;
        while (wq.size() == 0 && n < 200) begin
            @(posedge dtc_clk);
            n++;
        end
        if (wq.size() == 0) begin
            check("word_timeout", 32'd0, 32'd1);
            w = 16'h0000;
        end else begin
            w = wq.pop_front();
        end
    endtask

    task automatic get_nonsync(output logic [15:0] w, output int ns);
        ns = 0;
        get_word(w);
        while (w == SYNC_W && ns < 64) begin
            ns++;
            get_word(w);
        end
    endtask

    task automatic wait_strobe();
        int n = 0;
        @(negedge dtc_clk);
        while (!word_strobe && n < 16) begin
            @(negedge dtc_clk);
            n++;
        end
        check("strobe_seen", word_strobe, 1'b1);
    endtask

    // Align to a boundary, drop stale words, then pulse the chosen request lines
    task automatic pulse_req(input logic evt, input logic rd, input logic st);
        wait_strobe();
        wq.delete();
        rdocmd = evt; read = rd; streq = st;
        @(negedge dtc_clk);
        rdocmd = 1'b0; read = 1'b0; streq = 1'b0;
    endtask

    task automatic check_event_body(input evt_vec_t v);
        logic [15:0] w, e, chk;
`ifdef DTC_CRC16_EN
        chk = 16'hFFFF;
`else
        chk = 16'h0000;
`endif
        get_word(w); check("evt_info", w, v.exp_info);
        for (int ch = 0; ch < 64; ch++) begin
            if (v.mask[ch]) begin
                for (int a = int'(v.exp_info) - 1; a >= 0; a--) begin
                    e = 16'(adc_f(6'(ch), 6'(a)));
                    get_word(w); check("adc_word", w, e);
`ifdef DTC_CRC16_EN
                    chk = crc_step(chk, e);
`else
                    chk = chk ^ e;
`endif
                end
            end
        end
        get_word(w); check("trl_cnt", w, v.exp_cnt);
        get_word(w); check("trl_chk", w, chk);
        get_word(w); check("trl_end", w, 16'hC5D5);
    endtask

    task automatic expect_reply(input logic [31:0] a, input logic [31:0] d);
        logic [15:0] w;
        int ns;
        get_nonsync(w, ns); check("rpl_hdr", w, 16'hF7F7);
        get_word(w); check("addr_h", w, a[31:16]);
        get_word(w); check("addr_l", w, a[15:0]);
        get_word(w); check("data_h", w, d[31:16]);
        get_word(w); check("data_l", w, d[15:0]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] w, s;
        int ns;
        vecs[0] = '{7'd2,   64'h0000_0000_0000_0005, 16'h0002, 16'h0004};
        vecs[1] = '{7'd0,   64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 16'h0000};
        vecs[2] = '{7'd3,   64'h0000_0000_0000_0000, 16'h0003, 16'h0000};
        vecs[3] = '{7'd100, 64'h8000_0000_0000_0001, 16'h0040, 16'h0080};
        vecs[4] = '{7'd1,   64'hFFFF_FFFF_FFFF_FFFF, 16'h0001, 16'h0040};
        vecs[5] = '{7'd64,  64'h0000_0100_0000_0000, 16'h0040, 16'h0040};
        vecs[6] = '{7'd127, 64'h0000_0000_0000_0002, 16'h0040, 16'h0040};

        rst_n = 1'b0; rdocmd = 1'b0; streq = 1'b0; read = 1'b0; data_vld = 1'b0;
        event_window = 7'd0; ch_mask = 64'h0; status = 16'h1357;
        address = 32'h0; data = 32'h0;
        repeat (3) @(negedge dtc_clk);
        check("rst_dtc_out", dtc_out, 4'h0);
        check("rst_strobe", word_strobe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ch", adc_rd_ch, 6'd0);
        check("rst_addr", adc_rd_addr, 6'd0);
        rst_n = 1'b1;

        // Idle SYNC slices, LSB first
        wait_strobe();
        s = SYNC_W;
        for (int k = 0; k < WCYC; k++) begin
            check("idle_slice", dtc_out, 32'(s[2*LANES*k +: 2*LANES]));
            check("idle_busy", busy, 1'b0);
            @(negedge dtc_clk);
        end
        check("strobe_period", word_strobe, 1'b1);

        for (int i = 0; i < 7; i++) begin
            event_window = vecs[i].win;
            ch_mask = vecs[i].mask;
            pulse_req(1'b1, 1'b0, 1'b0);
            get_nonsync(w, ns); check("evt_hdr", w, 16'h5C5C);
            check("evt_busy", busy, 1'b1);
            check_event_body(vecs[i]);
            get_word(w); check("evt_sync_after", w, SYNC_W);
            check("evt_idle", busy, 1'b0);
        end

        // Read with data_vld ten clocks after the request
        address = 32'hFFFF_0000; data = 32'h0000_FFFF;
        pulse_req(1'b0, 1'b1, 1'b0);
        repeat (9) @(negedge dtc_clk);
        address = 32'h1234_5678; data = 32'hCAFE_BABE; data_vld = 1'b1;
        @(negedge dtc_clk);
        data_vld = 1'b0; address = 32'h1111_2222; data = 32'h3333_4444;
        expect_reply(32'h1234_5678, 32'hCAFE_BABE);

        // Read timeout: SYNC in flight + SYNC at take + three RD_WAIT SYNCs
        address = 32'h89AB_CDEF;
        pulse_req(1'b0, 1'b1, 1'b0);
        get_nonsync(w, ns);
        check("tmo_sync_count", 32'(ns), 32'd5);
        check("tmo_hdr", w, 16'hF7F7);
        get_word(w); check("tmo_addr_h", w, 16'h89AB);
        get_word(w); check("tmo_addr_l", w, 16'hCDEF);
        get_word(w); check("tmo_data_h", w, 16'hDEAD);
        get_word(w); check("tmo_data_l", w, 16'hDEAD);

        // Status alone
        pulse_req(1'b0, 1'b0, 1'b1);
        get_nonsync(w, ns); check("st_hdr", w, 16'hDCDC);
        get_word(w); check("st_word", w, 16'h1357);

        // Read and status (twice) arriving during an event
        event_window = vecs[0].win; ch_mask = vecs[0].mask; address = 32'hA5A5_0F0F;
        status = 16'h2468;
        pulse_req(1'b1, 1'b0, 1'b0);
        get_nonsync(w, ns); check("cc_evt_hdr", w, 16'h5C5C);
        read = 1'b1; @(negedge dtc_clk); read = 1'b0;
        repeat (3) @(negedge dtc_clk);
        streq = 1'b1; @(negedge dtc_clk); streq = 1'b0;
        repeat (5) @(negedge dtc_clk);
        streq = 1'b1; @(negedge dtc_clk); streq = 1'b0;
        check_event_body(vecs[0]);
        expect_reply(32'hA5A5_0F0F, 32'hDEAD_DEAD);
        get_nonsync(w, ns); check("cc_st_hdr", w, 16'hDCDC);
        get_word(w); check("cc_st_word", w, 16'h2468);
        for (int k = 0; k < 3; k++) begin
            get_word(w); check("cc_no_extra", w, SYNC_W);
        end
        check("cc_idle", busy, 1'b0);

        // Reset in the middle of a long event
        event_window = vecs[3].win; ch_mask = vecs[3].mask;
        pulse_req(1'b1, 1'b0, 1'b0);
        get_nonsync(w, ns); check("mr_evt_hdr", w, 16'h5C5C);
        repeat (6) @(negedge dtc_clk);
        rst_n = 1'b0;
        #1;
        check("mr_busy", busy, 1'b0);
        check("mr_dtc_out", dtc_out, 4'h0);
        check("mr_strobe", word_strobe, 1'b0);
        check("mr_addr", adc_rd_addr, 6'd0);
        repeat (2) @(negedge dtc_clk);
        rst_n = 1'b1;
        wq.delete();
        for (int k = 0; k < 3; k++) begin
            get_word(w); check("mr_sync", w, SYNC_W);
        end
        check("mr_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
